// File: rtl/gpio_pkg.sv
// Shared definitions for the memory-mapped GPIO port.
// Register offsets and the zero-extension helper for the read path.
package gpio_pkg;

  localparam logic [2:0] GPIO_IN      = 3'd0;
  localparam logic [2:0] GPIO_OUT     = 3'd1;
  localparam logic [2:0] GPIO_SET     = 3'd2;
  localparam logic [2:0] GPIO_CLR     = 3'd3;
  localparam logic [2:0] GPIO_STATUS  = 3'd4;
  localparam logic [2:0] GPIO_MASK    = 3'd5;
  localparam logic [2:0] GPIO_RISE_EN = 3'd6;
  localparam logic [2:0] GPIO_FALL_EN = 3'd7;

  function automatic logic [31:0] zext(
    input logic [31:0] v,
    input int unsigned w
  );
    logic [31:0] m;
    m = (32'h1 << w) - 32'h1;
    if (w >= 32) m = '1;
    return v & m;
  endfunction

endpackage

// File: rtl/gpio_mmio_port_sync.sv
// Multi-stage input synchroniser for the GPIO pins.
// Every stage clears on reset so edge detection starts from all-low.
module gpio_mmio_port_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++)
        chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++)
        chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/gpio_mmio_port.sv
// Bus-attached GPIO port: synchronised inputs, set/clear outputs,
// sticky edge capture with a maskable level interrupt.
module gpio_mmio_port #(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel,
  input  logic             we,
  input  logic             re,
  input  logic [2:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             rvalid,
  input  logic [WIDTH-1:0] GPIO_i,
  output logic [WIDTH-1:0] GPIO_o,
  output logic             irq
);

  import gpio_pkg::*;

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] status_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] rise_en_q;
  logic [WIDTH-1:0] fall_en_q;
  logic [WIDTH-1:0] rmux;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] w1c;
  logic             wr;
  logic             rd;
  logic             unused_wdata;

  gpio_mmio_port_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (GPIO_i),
    .q     (sync)
  );

  assign wr   = sel & we;
  assign rd   = sel & re;
  assign wd   = wdata[WIDTH-1:0];
  assign rise = sync & ~prev_q & rise_en_q;
  assign fall = ~sync & prev_q & fall_en_q;
  assign w1c  = (wr && addr == GPIO_STATUS) ? wd : '0;

  assign unused_wdata = &{1'b0, wdata};

  always_comb begin
    rmux = '0;
    unique case (addr)
      GPIO_IN:      rmux = sync;
      GPIO_OUT:     rmux = out_q;
      GPIO_SET:     rmux = out_q;
      GPIO_CLR:     rmux = out_q;
      GPIO_STATUS:  rmux = status_q;
      GPIO_MASK:    rmux = mask_q;
      GPIO_RISE_EN: rmux = rise_en_q;
      GPIO_FALL_EN: rmux = fall_en_q;
      default:      rmux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q    <= '0;
      out_q     <= OUT_RESET;
      status_q  <= '0;
      mask_q    <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      rdata     <= '0;
      rvalid    <= 1'b0;
      irq       <= 1'b0;
    end else begin
      prev_q   <= sync;
      // a new edge on a bit overrides a same-cycle W1C of that bit
      status_q <= (status_q & ~w1c) | rise | fall;
      irq      <= |(status_q & mask_q);
      rvalid   <= rd;
      if (rd)
        rdata <= zext(32'(rmux), WIDTH);
      if (wr) begin
        unique case (addr)
          GPIO_OUT:     out_q     <= wd;
          GPIO_SET:     out_q     <= out_q | wd;
          GPIO_CLR:     out_q     <= out_q & ~wd;
          GPIO_MASK:    mask_q    <= wd;
          GPIO_RISE_EN: rise_en_q <= wd;
          GPIO_FALL_EN: fall_en_q <= wd;
          default:      ;
        endcase
      end
    end
  end

  assign GPIO_o = out_q;

endmodule

// File: tb/tb_gpio_mmio_port.sv
// Directed bench for gpio_mmio_port (WIDTH=8, SYNC_STAGES=2,
// OUT_RESET=8'hA5); each step is driven on a falling clock edge.
module tb_gpio_mmio_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        we;
  logic        re;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gpio_mmio_port #(
    .WIDTH       (8),
    .SYNC_STAGES (2),
    .OUT_RESET   (8'hA5)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .sel    (sel),
    .we     (we),
    .re     (re),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .rvalid (rvalid),
    .GPIO_i (gpio_in),
    .GPIO_o (gpio_out),
    .irq    (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
    sel = 1'b1; re = 1'b1; addr = a;
    @(negedge clk);
    sel = 1'b0; re = 1'b0;
    chk("rvalid_pulse", 32'(rvalid), 32'h1);
    d = rdata;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  logic [31:0] r;

  initial begin
    reset = 1'b1; sel = 1'b0; we = 1'b0; re = 1'b0;
    addr = 3'd0; wdata = 32'h0; gpio_in = 8'h00;
    idle(3);
    reset = 1'b0;

    chk("rst_gpio_o", 32'(gpio_out), 32'hA5);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rdata", rdata, 32'h0);

    bus_rd(3'd1, r);
    chk("out_reset_read", r, 32'hA5);
    @(negedge clk);
    chk("rvalid_one_cycle", 32'(rvalid), 32'h0);

    bus_wr(3'd1, 32'h0000_000F);
    chk("out_write", 32'(gpio_out), 32'h0F);
    bus_wr(3'd2, 32'h0000_00F0);
    chk("set_write", 32'(gpio_out), 32'hFF);
    bus_wr(3'd3, 32'h0000_0003);
    chk("clr_write", 32'(gpio_out), 32'hFC);
    bus_rd(3'd2, r);
    chk("set_readback", r, 32'hFC);

    we = 1'b1; addr = 3'd1; wdata = 32'h0;
    @(negedge clk);
    we = 1'b0;
    chk("nosel_ignored", 32'(gpio_out), 32'hFC);

    sel = 1'b1; we = 1'b1; re = 1'b1; addr = 3'd1; wdata = 32'hFFFF_FF11;
    @(negedge clk);
    sel = 1'b0; we = 1'b0; re = 1'b0;
    chk("rw_pre_value", rdata, 32'hFC);
    chk("rw_write", 32'(gpio_out), 32'h11);

    gpio_in = 8'h03;
    @(negedge clk);
    bus_rd(3'd0, r);
    chk("in_before_latency", r, 32'h0);
    bus_rd(3'd0, r);
    chk("in_after_latency", r, 32'h0000_0003);

    bus_wr(3'd0, 32'hFF);
    bus_rd(3'd0, r);
    chk("in_write_ignored", r, 32'h0000_0003);

    gpio_in = 8'h00;
    idle(4);
    bus_wr(3'd6, 32'h01);
    bus_wr(3'd5, 32'h01);
    bus_rd(3'd6, r);
    chk("rise_en_read", r, 32'h01);
    gpio_in = 8'h01;
    idle(3);
    bus_rd(3'd4, r);
    chk("rise_status", r, 32'h01);
    chk("irq_set", 32'(irq), 32'h1);
    bus_wr(3'd4, 32'h01);
    chk("irq_lag", 32'(irq), 32'h1);
    @(negedge clk);
    chk("irq_cleared", 32'(irq), 32'h0);
    bus_rd(3'd4, r);
    chk("status_cleared", r, 32'h0);

    bus_wr(3'd7, 32'h02);
    gpio_in = 8'h03;
    idle(4);
    gpio_in = 8'h01;
    idle(3);
    bus_rd(3'd4, r);
    chk("fall_status", r, 32'h02);
    gpio_in = 8'h03;
    idle(4);
    gpio_in = 8'h01;
    idle(2);
    bus_wr(3'd4, 32'h02);
    bus_rd(3'd4, r);
    chk("set_beats_w1c", r, 32'h02);
    bus_wr(3'd4, 32'h02);
    bus_rd(3'd4, r);
    chk("w1c_no_edge", r, 32'h0);
    chk("irq_masked", 32'(irq), 32'h0);

    sel = 1'b1; re = 1'b1; addr = 3'd1; reset = 1'b1;
    @(negedge clk);
    sel = 1'b0; re = 1'b0;
    chk("rst_drops_read", 32'(rvalid), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    chk("rst2_gpio_o", 32'(gpio_out), 32'hA5);
    chk("rst2_rdata", rdata, 32'h0);
    chk("rst2_irq", 32'(irq), 32'h0);
    idle(4);
    bus_rd(3'd4, r);
    chk("rst2_status", r, 32'h0);
    bus_rd(3'd5, r);
    chk("rst2_mask", r, 32'h0);
    bus_rd(3'd6, r);
    chk("rst2_rise_en", r, 32'h0);
    bus_rd(3'd7, r);
    chk("rst2_fall_en", r, 32'h0);
    bus_rd(3'd3, r);
    chk("rst2_out", r, 32'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
